// File: rtl/fxyz_sweep_if.sv
// fxyz_sweep_if: host/datapath bundle for the fxyz truth-table sweep controller.
// Handshake: start is a level request. The controller samples it only while idle,
// that is, while state_dbg reads IDLE. An accepted start makes busy rise on the
// next edge. busy then stays high until the one-cycle done pulse has been seen.
// A start with an illegal func_sel is answered by a one-cycle err_sel pulse instead.
interface fxyz_sweep_if #(
    parameter int NUM_FUNCS = 5
);
    logic                 start;
    logic [2:0]           func_sel;
    logic [7:0]           expected;
    logic [NUM_FUNCS-1:0] f_in;
    logic                 x;
    logic                 y;
    logic                 z;
    logic                 busy;
    logic                 done;
    logic [7:0]           table_out;
    logic                 match;
    logic                 err_sel;
    logic [1:0]           state_dbg;

    // host / datapath side
    modport master (
        output start, func_sel, expected, f_in,
        input  x, y, z, busy, done, table_out, match, err_sel, state_dbg
    );

    // sweep controller side
    modport slave (
        input  start, func_sel, expected, f_in,
        output x, y, z, busy, done, table_out, match, err_sel, state_dbg
    );
endinterface

// File: rtl/fxyz_sweep_ctrl.sv
// fxyz_sweep_ctrl: walks {x,y,z} through 000..111 and holds each vector for
// SETTLE+1 cycles. It samples the selected function output at the end of each
// hold, builds the 8-bit truth table, and flags whether that table matches the
// reference.
// Optional build macro FXYZ_GOLDEN_EN: the reference comes from an internal
// golden ROM indexed by func_sel, and the expected port is ignored.
module fxyz_sweep_ctrl #(
    parameter int NUM_FUNCS = 5,
    parameter int SETTLE    = 1
) (
    input  logic         clk,
    input  logic         rst,
    fxyz_sweep_if.slave  bus
);
    localparam int HW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      sel_q;
    logic [2:0]      idx;
    logic [HW-1:0]   hold_cnt;
    logic [2:0]      vec_q;
    logic [7:0]      table_q;
    logic            busy_q;
    logic            done_q;
    logic            match_q;
    logic            err_q;
    logic            sel_legal;
    logic            hold_last;
    logic            f_bit;
    logic [7:0]      table_next;
    logic [7:0]      ref_table;

`ifdef FXYZ_GOLDEN_EN
    // Known-good tables for functions A..E; bit k is f({x,y,z}=k).
    function automatic logic [7:0] golden_table(input logic [2:0] s);
        case (s)
            3'd0:    golden_table = 8'h04;
            3'd1:    golden_table = 8'h40;
            3'd2:    golden_table = 8'h45;
            3'd3:    golden_table = 8'hA2;
            3'd4:    golden_table = 8'h44;
            default: golden_table = 8'h00;
        endcase
    endfunction

    assign ref_table = golden_table(sel_q);
`else
    logic [7:0] exp_q;

    assign ref_table = exp_q;
`endif

    assign sel_legal = (int'({29'd0, bus.func_sel}) < NUM_FUNCS);
    assign hold_last = (hold_cnt == HW'(SETTLE));
    assign f_bit     = bus.f_in[sel_q];

    // Table as it will look after the current sample lands; lets match use it on the same edge.
    always_comb begin
        table_next      = table_q;
        table_next[idx] = f_bit;
    end

    // Sweep sequencer: IDLE waits for a legal start, APPLY steps vectors, DONE pulses once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel_q    <= 3'd0;
            idx      <= 3'd0;
            hold_cnt <= '0;
            vec_q    <= 3'd0;
            table_q  <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
`ifndef FXYZ_GOLDEN_EN
            exp_q    <= 8'h00;
`endif
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (sel_legal) begin
                            sel_q    <= bus.func_sel;
`ifndef FXYZ_GOLDEN_EN
                            exp_q    <= bus.expected;
`endif
                            table_q  <= 8'h00;
                            match_q  <= 1'b0;
                            idx      <= 3'd0;
                            hold_cnt <= '0;
                            vec_q    <= 3'd0;
                            busy_q   <= 1'b1;
                            state    <= APPLY;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                APPLY: begin
                    if (hold_last) begin
                        table_q  <= table_next;
                        hold_cnt <= '0;
                        if (idx == 3'd7) begin
                            done_q  <= 1'b1;
                            match_q <= (table_next == ref_table);
                            state   <= DONE_ST;
                        end else begin
                            idx   <= idx + 3'd1;
                            vec_q <= idx + 3'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                DONE_ST: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.x         = vec_q[2];
    assign bus.y         = vec_q[1];
    assign bus.z         = vec_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.match     = match_q;
    assign bus.err_sel   = err_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_fxyz_sweep_ctrl.sv
// tb_fxyz_sweep_ctrl: directed, table-driven bench for fxyz_sweep_ctrl with a
// behavioural fxyzA..E datapath feeding f_in.
module tb_fxyz_sweep_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fxyz_sweep_if #(.NUM_FUNCS(5)) bus ();

    fxyz_sweep_ctrl #(.NUM_FUNCS(5), .SETTLE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // fxyzA..E written as boolean equations of x/y/z
    always_comb begin
        bus.f_in[0] = ~bus.x &  bus.y & ~bus.z;
        bus.f_in[1] =  bus.x &  bus.y & ~bus.z;
        bus.f_in[2] = ~bus.z & (~bus.x | bus.y);
        bus.f_in[3] =  bus.z & (~bus.y | bus.x);
        bus.f_in[4] =  bus.y & ~bus.z;
    end

    typedef struct {
        logic [2:0] sel;
        logic [7:0] expv;
        logic [7:0] tbl;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic ref_match(input logic [2:0] s, input logic [7:0] e, input logic [7:0] t);
`ifdef FXYZ_GOLDEN_EN
        logic [7:0] g;
        case (s)
            3'd0:    g = 8'h04;
            3'd1:    g = 8'h40;
            3'd2:    g = 8'h45;
            3'd3:    g = 8'hA2;
            default: g = 8'h44;
        endcase
        return (t == g);
`else
        if (s > 3'd4) return 1'b0;
        return (t == e);
`endif
    endfunction

    // One full sweep; lat = busy cycle in which done was seen (0 if never).
    task automatic run_sweep(input logic [2:0] s, input logic [7:0] e,
                             output int lat, output bit xyz_ok, output bit busy_ok);
        lat     = 0;
        xyz_ok  = 1'b1;
        busy_ok = 1'b1;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.func_sel = s;
        bus.expected = e;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (n > 1) @(negedge clk);
            if (n <= 16 && {bus.x, bus.y, bus.z} != 3'((n - 1) / 2)) xyz_ok = 1'b0;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                lat = n;
                if ({bus.x, bus.y, bus.z} != 3'b111) xyz_ok = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  xyz_ok;
        bit  busy_ok;
        int  dones;
        logic [7:0] t_prev;

        vecs[0] = '{sel: 3'd0, expv: 8'h04, tbl: 8'h04};
        vecs[1] = '{sel: 3'd3, expv: 8'hA3, tbl: 8'hA2};
        vecs[2] = '{sel: 3'd4, expv: 8'h44, tbl: 8'h44};
        vecs[3] = '{sel: 3'd1, expv: 8'h40, tbl: 8'h40};
        vecs[4] = '{sel: 3'd2, expv: 8'h00, tbl: 8'h45};
        vecs[5] = '{sel: 3'd2, expv: 8'h45, tbl: 8'h45};

        // reset then idle
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.func_sel = 3'd0;
        bus.expected = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_xyz",   32'({bus.x, bus.y, bus.z}), 32'd0);
        check("reset_busy",  32'(bus.busy), 32'd0);
        check("reset_done",  32'(bus.done), 32'd0);
        check("reset_table", 32'(bus.table_out), 32'h00);
        check("reset_match", 32'(bus.match), 32'd0);
        check("reset_err",   32'(bus.err_sel), 32'd0);
        check("reset_state", 32'(bus.state_dbg), 32'd0);

        // table-driven sweeps
        for (int i = 0; i < 6; i++) begin
            run_sweep(vecs[i].sel, vecs[i].expv, lat, xyz_ok, busy_ok);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd17);
            check($sformatf("v%0d_xyz_seq", i), 32'(xyz_ok), 32'd1);
            check($sformatf("v%0d_busy", i), 32'(busy_ok), 32'd1);
            check($sformatf("v%0d_table", i), 32'(bus.table_out), 32'(vecs[i].tbl));
            check($sformatf("v%0d_match", i), 32'(bus.match),
                  32'(ref_match(vecs[i].sel, vecs[i].expv, vecs[i].tbl)));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
            check($sformatf("v%0d_busy_drop", i), 32'(bus.busy), 32'd0);
            check($sformatf("v%0d_table_hold", i), 32'(bus.table_out), 32'(vecs[i].tbl));
            check($sformatf("v%0d_match_hold", i), 32'(bus.match),
                  32'(ref_match(vecs[i].sel, vecs[i].expv, vecs[i].tbl)));
            check($sformatf("v%0d_xyz_keep", i), 32'({bus.x, bus.y, bus.z}), 32'd7);
        end

        // illegal func_sel in IDLE: one-cycle err_sel, nothing else moves
        for (int s = 5; s <= 7; s += 2) begin
            @(negedge clk);
            bus.start    = 1'b1;
            bus.func_sel = 3'(s);
            @(negedge clk);
            check($sformatf("err%0d_pulse", s), 32'(bus.err_sel), 32'd1);
            check($sformatf("err%0d_busy", s), 32'(bus.busy), 32'd0);
            check($sformatf("err%0d_table", s), 32'(bus.table_out), 32'h45);
            check($sformatf("err%0d_xyz", s), 32'({bus.x, bus.y, bus.z}), 32'd7);
            bus.start = 1'b0;
            @(negedge clk);
            check($sformatf("err%0d_clear", s), 32'(bus.err_sel), 32'd0);
        end

        // start held high through a whole sweep: exactly one done
        @(negedge clk);
        bus.start    = 1'b1;
        bus.func_sel = 3'd0;
        bus.expected = 8'h04;
        dones = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("held_start_dones", 32'(dones), 32'd1);
        check("held_start_idle", 32'(bus.busy), 32'd0);
        check("held_start_table", 32'(bus.table_out), 32'h04);

        // extra start pulse in the 6th busy cycle is ignored, not queued
        @(negedge clk);
        bus.start    = 1'b1;
        bus.func_sel = 3'd4;
        bus.expected = 8'h44;
        dones = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            bus.start = (n == 6);
            if (bus.done) dones++;
        end
        bus.start = 1'b0;
        check("pulse_start_dones", 32'(dones), 32'd1);
        check("pulse_start_idle", 32'(bus.busy), 32'd0);
        check("pulse_start_table", 32'(bus.table_out), 32'h44);

        // reset in the 9th busy cycle aborts the sweep
        @(negedge clk);
        bus.start    = 1'b1;
        bus.func_sel = 3'd3;
        bus.expected = 8'hA2;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        t_prev = bus.table_out;
        check("abort_partial_table", 32'(t_prev), 32'h02);
        rst = 1'b1;
        #1;
        check("abort_xyz",   32'({bus.x, bus.y, bus.z}), 32'd0);
        check("abort_busy",  32'(bus.busy), 32'd0);
        check("abort_table", 32'(bus.table_out), 32'h00);
        check("abort_state", 32'(bus.state_dbg), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);

        run_sweep(3'd2, 8'h00, lat, xyz_ok, busy_ok);
        check("post_abort_latency", 32'(lat), 32'd17);
        check("post_abort_xyz_seq", 32'(xyz_ok), 32'd1);
        check("post_abort_table", 32'(bus.table_out), 32'h45);
        check("post_abort_match", 32'(bus.match), 32'(ref_match(3'd2, 8'h00, 8'h45)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
